microwave_ctrl: RTL



---
 rtl/mw_pkg.sv | 20 ++
 rtl/mw_tick_prescaler.sv | 31 +++
 rtl/microwave_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mw_pkg.sv
// Shared types and sizing helpers for the microwave cooking-cycle controller.
package mw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Never returns less than 1, so a counter for a modulus of 1 still has one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mw_tick_prescaler.sv
// Modulo-DIV cycle counter; o_tick is high on the last count while i_run is high.
// The count holds whenever i_run is low; i_clear returns it to 0 and wins over i_run.
module mw_tick_prescaler
  import mw_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = i_run & w_wrap;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Cooking-cycle controller driving a countdown timer, the magnetron and the buzzer.
// Define MW_DOOR_LOCK_EN to add a registered door_lock output that is high while cooking.
module microwave_ctrl
  import mw_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int BEEP_CYCLES = 3
) (
  input  logic clk,
  input  logic clear,
  input  logic key_valid,
  input  logic start,
  input  logic stop,
  input  logic door_closed,
  input  logic timer_zero,
  output logic timer_load,
  output logic timer_enable,
  output logic timer_clear,
  output logic mag_on,
`ifdef MW_DOOR_LOCK_EN
  output logic door_lock,
`endif
  output logic done_beep
);

  localparam int BW = clog2(BEEP_CYCLES + 1);
  localparam logic [BW-1:0] BEEP_INIT = BW'(BEEP_CYCLES);
  localparam logic [BW-1:0] BEEP_LAST = BW'(1);

  state_t        r_state;
  state_t        w_next;
  logic          r_start_q;
  logic          r_stop_q;
  logic [BW-1:0] r_beep;
  logic          w_start_rise;
  logic          w_stop_rise;
  logic          w_beep_load;
  logic          w_pre_clear;
  logic          w_run;
  logic          w_tick;

  assign w_start_rise = start & ~r_start_q;
  assign w_stop_rise  = stop & ~r_stop_q;
  assign w_run        = (r_state == COOK) & ~clear;

  mw_tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .i_clear (clear | w_pre_clear),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next       = r_state;
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    timer_clear  = 1'b0;
    mag_on       = 1'b0;
    done_beep    = 1'b0;
    w_beep_load  = 1'b0;
    w_pre_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          timer_load = 1'b1;
          w_next     = SET;
        end
      end
      SET: begin
        if (w_stop_rise) begin
          timer_clear = 1'b1;
          w_next      = IDLE;
        end else if (w_start_rise && door_closed && !timer_zero) begin
          w_pre_clear = 1'b1;
          w_next      = COOK;
        end else if (key_valid) begin
          timer_load = 1'b1;
        end
      end
      COOK: begin
        // Gated by the door directly so the magnetron drops in the very cycle it opens.
        mag_on       = door_closed;
        timer_enable = w_tick;
        if (w_stop_rise || !door_closed) begin
          w_next = PAUSE;
        end else if (timer_zero) begin
          w_beep_load = 1'b1;
          w_next      = DONE;
        end
      end
      PAUSE: begin
        if (w_stop_rise) begin
          timer_clear = 1'b1;
          w_next      = IDLE;
        end else if (w_start_rise && door_closed) begin
          w_next = COOK;
        end
      end
      DONE: begin
        done_beep = 1'b1;
        if (w_stop_rise || !door_closed || (r_beep <= BEEP_LAST)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (clear) begin
      w_next       = IDLE;
      timer_load   = 1'b0;
      timer_enable = 1'b0;
      timer_clear  = 1'b1;
      mag_on       = 1'b0;
      done_beep    = 1'b0;
      w_beep_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_beep    <= '0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start;
      r_stop_q  <= stop;
      if (w_beep_load) begin
        r_beep <= BEEP_INIT;
      end else if ((r_state == DONE) && (r_beep != '0)) begin
        r_beep <= r_beep - 1'b1;
      end
    end
  end

`ifdef MW_DOOR_LOCK_EN
  logic r_door_lock;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_door_lock <= 1'b0;
    end else begin
      r_door_lock <= (w_next == COOK);
    end
  end

  assign door_lock = r_door_lock & ~clear;
`endif

endmodule
